// File: rtl/sd_seq_gen.sv
// Serial sequence generator: shifts handshaked parallel words out MSB-first and runs an
// overlap-aware reference matcher on its own line, aligned with a Moore detector's output.
module sd_seq_gen #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter logic IDLE_BIT = 1'b0,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sequence_out,
    output logic             out_valid,
    output logic             busy,
    output logic             expected_detect,
    output logic [CNT_W-1:0] detect_count
);

    localparam int unsigned IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic {StIdle, StShift} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [PAT_LEN-2:0] hist_q, hist_d;
    logic               det_q, det_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               accept;
    logic [PAT_LEN-1:0] window;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            shreg_q <= '0;
            hist_q  <= '0;
            det_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            hist_q  <= hist_d;
            det_q   <= det_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        shreg_d      = shreg_q;
        load_ready   = (state_q == StIdle) || (idx_q == LAST_IDX);
        accept       = load_valid && load_ready;
        sequence_out = IDLE_BIT;
        out_valid    = 1'b0;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StShift;
                    shreg_d = load_data;
                    idx_d   = '0;
                end
            end
            StShift: begin
                sequence_out = shreg_q[LAST_IDX - idx_q];
                out_valid    = 1'b1;
                if (idx_q == LAST_IDX) begin
                    // Reload on the last bit keeps back-to-back words gapless.
                    idx_d = '0;
                    if (accept) begin
                        shreg_d = load_data;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // Idle bits enter the window too, since a downstream detector sees them.
        window = {hist_q, sequence_out};
        hist_d = window[PAT_LEN-2:0];
        det_d  = (window == PATTERN);
        cnt_d  = (det_q && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    assign busy            = out_valid;
    assign expected_detect = det_q;
    assign detect_count    = cnt_q;

endmodule
